multiplier_4b: RTL and testbench

- 4x4-bit integer multiplier with a runtime signedness select and an 8-bit registered product.
- c=0 treats operands as unsigned. c=1 treats operands as two's-complement signed.
- Used as a small arithmetic leaf in datapaths. One-cycle registered latency, with a valid flag travelling alongside the data.
- Product logic is a combinational partial-product array followed by an output register.

---
 rtl/multiplier_pkg.sv | 10 +
 rtl/multiplier_4b_pp_row.sv | 34 +++
 rtl/multiplier_4b.sv | 72 +++++++
 tb/tb_multiplier_4b.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/multiplier_pkg.sv
// Shared widths and mode encodings for the 4x4 signed/unsigned multiplier.
package multiplier_pkg;

    localparam int MUL_W  = 4;
    localparam int PROD_W = 2 * MUL_W;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/multiplier_4b_pp_row.sv
// One row of the array multiplier: adds a gated, shifted copy of the multiplicand
// into the running sum through a ripple chain of full adders (result kept modulo 2^PROD_W).
module mul_pp_row #(
    parameter int PROD_W = 8,
    parameter int SHIFT  = 0
) (
    input  logic [PROD_W-1:0] sum_in,
    input  logic [PROD_W-1:0] a_ext,
    input  logic              b_bit,
    output logic [PROD_W-1:0] sum_out
);

    logic [PROD_W-1:0] pp;
    logic [PROD_W-2:0] cy;

    assign pp = (a_ext & {PROD_W{b_bit}}) << SHIFT;

    for (genvar i = 0; i < PROD_W; i++) begin : g_fa
        logic cin;
        if (i == 0) begin : g_c0
            assign cin = 1'b0;
        end else begin : g_cn
            assign cin = cy[i-1];
        end

        assign sum_out[i] = sum_in[i] ^ pp[i] ^ cin;

        // Carry out of the top bit falls off the end of the product width.
        if (i < PROD_W - 1) begin : g_cy
            assign cy[i] = (sum_in[i] & pp[i]) | (cin & (sum_in[i] ^ pp[i]));
        end
    end

endmodule

// File: rtl/multiplier_4b.sv
// 4x4 array multiplier with runtime signed/unsigned select and a one-cycle
// registered product plus matching valid flag.
module multiplier_4b
    import multiplier_pkg::*;
#(
    parameter int WIDTH = MUL_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 c,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   p,
    output logic                 out_valid
);

    localparam int PW = 2 * WIDTH;

    logic [PW-1:0]       a_ext;
    logic [PW-1:0]       b_ext;
    logic [PW:0][PW-1:0] sum_chain;
    logic [PW-1:0]       p_d, p_q;
    logic                out_valid_d, out_valid_q;

    // Signed mode sign-extends both operands to the full product width; the low
    // PW bits of the wide product are then exact two's-complement results.
    always_comb begin
        a_ext = {{WIDTH{1'b0}}, a};
        b_ext = {{WIDTH{1'b0}}, b};
        if (c == MODE_SIGNED) begin
            a_ext = {{WIDTH{a[WIDTH-1]}}, a};
            b_ext = {{WIDTH{b[WIDTH-1]}}, b};
        end
    end

    assign sum_chain[0] = '0;

    for (genvar r = 0; r < PW; r++) begin : g_row
        mul_pp_row #(
            .PROD_W (PW),
            .SHIFT  (r)
        ) u_row (
            .sum_in  (sum_chain[r]),
            .a_ext   (a_ext),
            .b_bit   (b_ext[r]),
            .sum_out (sum_chain[r+1])
        );
    end

    always_comb begin
        p_d         = p_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            p_d = sum_chain[PW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign p         = p_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multiplier_4b.sv
// Directed-vector and exhaustive bench for multiplier_4b.
module tb_multiplier_4b;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       c;
    logic [3:0] a, b;
    logic [7:0] p;
    logic       out_valid;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic       c;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[17];

    multiplier_4b dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .c         (c),
        .a         (a),
        .b         (b),
        .p         (p),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [7:0] ref_mul(input logic cm, input logic [3:0] x, input logic [3:0] y);
        int sx, sy, pr;
        sx = cm ? ((x >= 8) ? int'(x) - 16 : int'(x)) : int'(x);
        sy = cm ? ((y >= 8) ? int'(y) - 16 : int'(y)) : int'(y);
        pr = sx * sy;
        return pr[7:0];
    endfunction

    // Drive on the falling edge, sample 1 time unit after the next rising edge.
    task automatic issue(input logic v, input logic cm, input logic [3:0] x, input logic [3:0] y);
        @(negedge clk);
        in_valid = v; c = cm; a = x; b = y;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] held;

        vecs[0]  = '{1'b0, 4'h0, 4'h7, 8'h00};
        vecs[1]  = '{1'b0, 4'h1, 4'h7, 8'h07};
        vecs[2]  = '{1'b0, 4'h2, 4'h7, 8'h0E};
        vecs[3]  = '{1'b0, 4'h3, 4'h7, 8'h15};
        vecs[4]  = '{1'b0, 4'h3, 4'hF, 8'h2D};
        vecs[5]  = '{1'b0, 4'hF, 4'hF, 8'hE1};
        vecs[6]  = '{1'b1, 4'h0, 4'h7, 8'h00};
        vecs[7]  = '{1'b1, 4'h1, 4'h7, 8'h07};
        vecs[8]  = '{1'b1, 4'h2, 4'h7, 8'h0E};
        vecs[9]  = '{1'b1, 4'h3, 4'h7, 8'h15};
        vecs[10] = '{1'b1, 4'h3, 4'hF, 8'hFD};
        vecs[11] = '{1'b1, 4'h8, 4'h8, 8'h40};
        vecs[12] = '{1'b1, 4'h8, 4'h7, 8'hC8};
        vecs[13] = '{1'b1, 4'hF, 4'hF, 8'h01};
        vecs[14] = '{1'b1, 4'h8, 4'hF, 8'h08};
        vecs[15] = '{1'b0, 4'h3, 4'hF, 8'h2D};
        vecs[16] = '{1'b1, 4'h3, 4'hF, 8'hFD};

        rst = 1'b1; in_valid = 1'b0; c = 1'b0; a = 4'h0; b = 4'h0;
        #3;
        check("reset_p", p, 8'h00);
        check("reset_vld", {7'b0, out_valid}, 8'h00);

        @(negedge clk);
        rst = 1'b0;

        // Async reset mid-stream; the in-flight op must be discarded.
        issue(1'b1, 1'b0, 4'h5, 4'h5);
        check("pre_rst_p", p, 8'h19);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_p", p, 8'h00);
        check("async_rst_vld", {7'b0, out_valid}, 8'h00);
        @(posedge clk);
        #1;
        check("rst_hold_p", p, 8'h00);
        check("rst_hold_vld", {7'b0, out_valid}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_p", p, 8'h00);
        check("post_rst_vld", {7'b0, out_valid}, 8'h00);
        issue(1'b1, 1'b0, 4'h1, 4'h7);
        check("first_after_rst", p, 8'h07);
        check("first_after_rst_vld", {7'b0, out_valid}, 8'h01);

        // Back-to-back table: unsigned/signed sweeps, signed corners, mode toggle.
        for (int i = 0; i < 17; i++) begin
            issue(1'b1, vecs[i].c, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_p", i), p, vecs[i].exp);
            check($sformatf("vec%0d_vld", i), {7'b0, out_valid}, 8'h01);
        end

        // Valid gating: random operands with in_valid low must leave p alone.
        held = p;
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            check($sformatf("gate%0d_p", i), p, held);
            check($sformatf("gate%0d_vld", i), {7'b0, out_valid}, 8'h00);
        end

        // Exhaustive sweep of every (c,a,b) against the integer reference model.
        for (int k = 0; k < 512; k++) begin
            logic cm;
            logic [3:0] x, y;
            cm = k[8];
            x  = k[7:4];
            y  = k[3:0];
            issue(1'b1, cm, x, y);
            check($sformatf("exh_c%0d_a%h_b%h", cm, x, y), p, ref_mul(cm, x, y));
        end

        issue(1'b0, 1'b0, 4'h0, 4'h0);
        check("final_vld", {7'b0, out_valid}, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
